// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int MAX_WORDS      = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Byte-to-word packer: places serial bytes little-endian into a word and
// tracks which byte lane is next.
module word_packer
  import imem_loader_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         xfer,
  input  logic [7:0]   byte_in,
  output logic         last,
  output logic [N-1:0] word_nxt
);

  localparam int BCW = $clog2(BYTES_PER_WORD);

  logic [BCW-1:0]                      byte_cnt;
  logic [BYTES_PER_WORD-1:0][7:0]      lanes;
  logic [BYTES_PER_WORD-1:0][7:0]      lanes_nxt;

  // each lane captures the incoming byte only when it is the addressed lane
  for (genvar g = 0; g < BYTES_PER_WORD; g++) begin : g_lane
    assign lanes_nxt[g] = (xfer && byte_cnt == BCW'(g)) ? byte_in : lanes[g];
  end

  assign last     = (byte_cnt == BCW'(BYTES_PER_WORD - 1));
  // word including the byte arriving this cycle, so the top can latch it on
  // the completing transfer without an extra stage
  assign word_nxt = N'(lanes_nxt);

  // lane storage and byte counter; clr (start/abort) wins over a transfer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lanes    <= '0;
      byte_cnt <= '0;
    end else if (clr) begin
      lanes    <= '0;
      byte_cnt <= '0;
    end else if (xfer) begin
      lanes    <= lanes_nxt;
      byte_cnt <= last ? '0 : byte_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Serial program loader: collects bytes into words and writes them into
// instruction memory, keeping the CPU held off (busy) while loading.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int N  = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   num_words,
  input  logic          abort,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [N-1:0]  wdata,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  checksum
);

  state_t          state;
  logic [AW:0]     nw_q;
  logic [AW-1:0]   word_cnt;
  logic            nw_ok;
  logic            start_ok;
  logic            abort_act;
  logic            xfer;
  logic            byte_last;
  logic            word_last;
  logic [N-1:0]    word_nxt;

  assign nw_ok     = (num_words != '0) && (num_words <= (AW+1)'(MAX_WORDS));
  assign start_ok  = start && (state == IDLE || state == DONE);
  assign abort_act = abort && (state == COLLECT || state == WRITE);
  assign xfer      = byte_ready && byte_valid && !abort;
  assign word_last = ({1'b0, word_cnt} == nw_q - 1'b1);

  assign byte_ready = (state == COLLECT);
  assign busy       = (state == COLLECT) || (state == WRITE);
  assign done       = (state == DONE);
  // abort in the WRITE cycle must suppress the write in that same cycle
  assign we         = (state == WRITE) && !abort;

  word_packer #(.N(N)) u_packer (
    .clk      (clk),
    .reset    (reset),
    .clr      (start_ok || abort_act),
    .xfer     (xfer),
    .byte_in  (byte_in),
    .last     (byte_last),
    .word_nxt (word_nxt)
  );

  // session FSM, word counter, write port registers and running checksum
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      nw_q     <= '0;
      word_cnt <= '0;
      waddr    <= '0;
      wdata    <= '0;
      checksum <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            nw_q     <= num_words;
            word_cnt <= '0;
            checksum <= '0;
            state    <= nw_ok ? COLLECT : DONE;
          end
        end
        COLLECT: begin
          if (abort) begin
            state <= IDLE;
          end else if (xfer && byte_last) begin
            waddr <= word_cnt;
            wdata <= word_nxt;
            state <= WRITE;
          end
        end
        WRITE: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            checksum <= checksum ^ wdata;
            if (word_last) begin
              state <= DONE;
            end else begin
              word_cnt <= word_cnt + 1'b1;
              state    <= COLLECT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of sessions plus hand-written
// abort/reset sequences, with a write scoreboard.
module tb_imem_loader;

  localparam int N  = 32;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   num_words = '0;
  logic          abort = 1'b0;
  logic [7:0]    byte_in = '0;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [N-1:0]  wdata;
  logic          busy;
  logic          done;
  logic [N-1:0]  checksum;

  imem_loader #(.N(N), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_words  (num_words),
    .abort      (abort),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] a;
    logic [N-1:0]  d;
    int            c;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];
  wr_t mon_w;

  // capture every write the DUT performs
  always @(negedge clk) begin
    if (we === 1'b1) begin
      mon_w.a = waddr;
      mon_w.d = wdata;
      mon_w.c = cyc;
      obs_q.push_back(mon_w);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_session(input int nw);
    num_words = nw[AW:0];
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // send nb bytes of w; optionally check we rises the cycle after byte 3
  task automatic send_word(input logic [N-1:0] w, input bit gap, input bit chk_we, input int nb);
    int t;
    for (int k = 0; k < nb; k++) begin
      if (gap) begin
        byte_valid = 1'b0;
        tick();
      end
      byte_in    = w[8*k +: 8];
      byte_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (byte_ready !== 1'b1 && t < 50) begin
        t++;
        @(negedge clk);
      end
      if (t >= 50) chk("ready_timeout", byte_ready, 1);
      tick();
    end
    byte_valid = 1'b0;
    if (chk_we) begin
      @(negedge clk);
      chk("we_latency", we, 1);
    end
  endtask

  task automatic push_exp(input int idx, input logic [N-1:0] w);
    wr_t e;
    e.a = idx[AW-1:0];
    e.d = w;
    e.c = 0;
    exp_q.push_back(e);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    chk("done", done, 1);
  endtask

  task automatic drain(input bit spacing);
    wr_t e;
    wr_t o;
    int  prev;
    prev = -1;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk("waddr", o.a, e.a);
      chk("wdata", o.d, e.d);
      if (spacing && prev >= 0) chk("word_spacing", o.c - prev, 5);
      prev = o.c;
    end
    chk("extra_writes", obs_q.size(), 0);
    chk("missing_writes", exp_q.size(), 0);
    obs_q.delete();
    exp_q.delete();
  endtask

  typedef struct {
    int           nw;
    bit           gap;
    logic [N-1:0] w0;
    logic [N-1:0] w1;
    logic [N-1:0] w2;
    logic [N-1:0] ck;
  } vec_t;

  vec_t vt[6];

  initial begin
    logic [N-1:0] w;
    logic [N-1:0] ck;
    logic [N-1:0] ws[3];

    vt[0] = '{1,  1'b0, 32'hF8000001, 32'h0,        32'h0,        32'hF8000001};
    vt[1] = '{2,  1'b1, 32'h8B050083, 32'hCB050083, 32'h0,        32'h40000000};
    vt[2] = '{3,  1'b0, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'h87878787};
    vt[3] = '{2,  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h00000000};
    vt[4] = '{0,  1'b0, 32'h0,        32'h0,        32'h0,        32'h00000000};
    vt[5] = '{65, 1'b1, 32'h0,        32'h0,        32'h0,        32'h00000000};

    // reset state
    #12;
    chk("rst_we", we, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_checksum", checksum, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_byte_ready", byte_ready, 0);
    tick();
    reset = 1'b1;
    tick();

    // table-driven sessions
    for (int i = 0; i < 6; i++) begin
      start_session(vt[i].nw);
      if (vt[i].nw >= 1 && vt[i].nw <= 64) begin
        chk("busy_collect", busy, 1);
        ws[0] = vt[i].w0;
        ws[1] = vt[i].w1;
        ws[2] = vt[i].w2;
        for (int j = 0; j < vt[i].nw; j++) begin
          push_exp(j, ws[j]);
          send_word(ws[j], vt[i].gap, 1'b1, 4);
        end
        wait_done();
        chk("busy_after_done", busy, 0);
        chk("byte_ready_done", byte_ready, 0);
      end else begin
        chk("bad_nw_done", done, 1);
        chk("bad_nw_busy", busy, 0);
      end
      chk("checksum", checksum, vt[i].ck);
      tick();
      drain(1'b0);
    end

    // 64 back-to-back words: full address range, 5 cycles per word
    start_session(64);
    ck = '0;
    for (int j = 0; j < 64; j++) begin
      w = $urandom;
      ck ^= w;
      push_exp(j, w);
      send_word(w, 1'b0, 1'b0, 4);
    end
    wait_done();
    chk("checksum64", checksum, ck);
    repeat (3) tick();
    drain(1'b1);

    // abort after two bytes of the fourth word; start mid-session ignored
    start_session(5);
    ck = '0;
    for (int j = 0; j < 3; j++) begin
      w = 32'hA5000000 + j * 32'h01010101;
      ck ^= w;
      push_exp(j, w);
      send_word(w, 1'b0, 1'b0, 4);
      if (j == 0) begin
        num_words = 7'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
      end
    end
    send_word(32'hDEADBEEF, 1'b0, 1'b0, 2);
    byte_in    = 8'hDE;
    byte_valid = 1'b1;
    abort      = 1'b1;
    tick();
    abort      = 1'b0;
    byte_valid = 1'b0;
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", byte_ready, 0);
    chk("abort_checksum", checksum, ck);
    repeat (4) tick();
    drain(1'b0);
    start_session(1);
    push_exp(0, 32'h01020304);
    send_word(32'h01020304, 1'b0, 1'b1, 4);
    wait_done();
    chk("restart_checksum", checksum, 32'h01020304);
    drain(1'b0);

    // abort landing on the WRITE cycle suppresses the write
    start_session(2);
    send_word(32'h11223344, 1'b0, 1'b0, 4);
    abort = 1'b1;
    @(negedge clk);
    chk("abort_write_we", we, 0);
    tick();
    abort = 1'b0;
    chk("abort_write_busy", busy, 0);
    chk("abort_write_done", done, 0);
    chk("abort_write_checksum", checksum, 0);
    tick();
    drain(1'b0);

    // reset in the WRITE cycle of word 1
    start_session(2);
    push_exp(0, 32'h55AA55AA);
    send_word(32'h55AA55AA, 1'b0, 1'b1, 4);
    send_word(32'h0BADF00D, 1'b0, 1'b0, 4);
    reset = 1'b0;
    #1;
    chk("mid_rst_we", we, 0);
    chk("mid_rst_waddr", waddr, 0);
    chk("mid_rst_wdata", wdata, 0);
    chk("mid_rst_checksum", checksum, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ready", byte_ready, 0);
    tick();
    reset = 1'b1;
    tick();
    start_session(0);
    chk("nw0_done", done, 1);
    chk("nw0_checksum", checksum, 0);
    tick();
    drain(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
